// File: rtl/fp_acc_pkg.sv
// fp_acc_pkg: widths, FSM encoding, float constants and unpack helper for fp_pair_accumulator
package fp_acc_pkg;
    localparam int FLT_DATA_WIDTH = 32;
    localparam int EXP_WIDTH = 8;
    localparam int MAN_WIDTH = 23;
    localparam int ADD_LATENCY = 3;
    localparam int FIFO_DEPTH = 2;
    localparam logic [FLT_DATA_WIDTH-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [EXP_WIDTH-1:0] FP_EXP_MAX = 8'hFF;
    typedef enum logic [1:0] {IDLE, ADD_ONE, ADD_TWO, DONE} state_t;
    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAN_WIDTH:0]   man;
    } ufloat_t;
    function automatic ufloat_t unpack(input logic [FLT_DATA_WIDTH-1:0] f);
        ufloat_t u;
        u.sign = f[FLT_DATA_WIDTH-1];
        u.exp = f[MAN_WIDTH +: EXP_WIDTH];
        u.man = (u.exp == '0) ? '0 : {1'b1, f[MAN_WIDTH-1:0]};
        return u;
    endfunction
endpackage

// File: rtl/fp_acc_add_core.sv
// fp_add_core: 3-stage truncating float32 adder (align / add / normalise+pack), stalled by clk_en
module fp_add_core
    import fp_acc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [FLT_DATA_WIDTH-1:0] i_a,
    input  logic [FLT_DATA_WIDTH-1:0] i_b,
    output logic [FLT_DATA_WIDTH-1:0] o_sum
);
    localparam int XW = MAN_WIDTH + 4;
    ufloat_t w_a, w_b, w_big, w_small;
    logic w_swap, w_a_inf, w_b_inf;
    logic [EXP_WIDTH-1:0] w_diff;
    logic [XW-1:0] w_big_x, w_small_x, w_al;
    logic r1_sub, r1_sign, r1_inf;
    logic [EXP_WIDTH-1:0] r1_exp;
    logic [XW-1:0] r1_big, r1_small;
    logic r2_sign, r2_inf;
    logic [EXP_WIDTH-1:0] r2_exp;
    logic [XW:0] r2_sum;
    logic [4:0] w_lz;
    logic [XW-1:0] w_norm;
    logic signed [EXP_WIDTH+1:0] w_e;
    logic [FLT_DATA_WIDTH-1:0] w_pack;
    assign w_a = unpack(i_a);
    assign w_b = unpack(i_b);
    assign w_a_inf = w_a.exp == FP_EXP_MAX;
    assign w_b_inf = w_b.exp == FP_EXP_MAX;
    assign w_swap = {w_b.exp, w_b.man} > {w_a.exp, w_a.man};
    assign w_big = w_swap ? w_b : w_a;
    assign w_small = w_swap ? w_a : w_b;
    assign w_diff = w_big.exp - w_small.exp;
    assign w_big_x = {w_big.man, 3'b000};
    assign w_small_x = {w_small.man, 3'b000};
    // guard/round bits plus a sticky LSB keep truncation exact on subtraction
    assign w_al = (w_small_x >> w_diff) | XW'(|(w_small_x & ~({XW{1'b1}} << w_diff)));
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < XW; i++)
            if (r2_sum[i]) w_lz = 5'(XW - 1 - i);
        w_norm = r2_sum[XW-1:0] << w_lz;
        w_e = r2_sum[XW] ? $signed({2'b00, r2_exp}) + 10'sd1 : $signed({2'b00, r2_exp}) - $signed({5'b0, w_lz});
        w_pack = (r2_inf || w_e >= 10'sd255) ? {r2_sign, FP_EXP_MAX, {MAN_WIDTH{1'b0}}}
               : (r2_sum == '0 || w_e <= 10'sd0) ? FP_POS_ZERO
               : {r2_sign, w_e[EXP_WIDTH-1:0], r2_sum[XW] ? r2_sum[XW-1:4] : w_norm[XW-2:3]};
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r1_sub <= 1'b0;
            r1_sign <= 1'b0;
            r1_inf <= 1'b0;
            r1_exp <= '0;
            r1_big <= '0;
            r1_small <= '0;
            r2_sign <= 1'b0;
            r2_inf <= 1'b0;
            r2_exp <= '0;
            r2_sum <= '0;
            o_sum <= FP_POS_ZERO;
        end else if (clk_en) begin
            r1_sub <= w_big.sign ^ w_small.sign;
            r1_inf <= w_a_inf || w_b_inf;
            r1_sign <= w_a_inf ? w_a.sign : w_b_inf ? w_b.sign : w_big.sign;
            r1_exp <= w_big.exp;
            r1_big <= w_big_x;
            r1_small <= w_al;
            r2_sign <= r1_sign;
            r2_inf <= r1_inf;
            r2_exp <= r1_exp;
            r2_sum <= r1_sub ? {1'b0, r1_big} - {1'b0, r1_small} : {1'b0, r1_big} + {1'b0, r1_small};
            o_sum <= w_pack;
        end
endmodule

// File: rtl/fp_pair_accumulator.sv
// fp_pair_accumulator: new_total = (total + one) + two on a shared adder; FP_ACC_FIFO_EN adds a pending-pair FIFO
module fp_pair_accumulator
    import fp_acc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [FLT_DATA_WIDTH-1:0] curent_total,
    input  logic [FLT_DATA_WIDTH-1:0] to_add_one,
    input  logic [FLT_DATA_WIDTH-1:0] to_add_two,
    output logic [FLT_DATA_WIDTH-1:0] new_total,
    output logic                      done,
    output logic                      working,
    output logic                      overrun
);
    state_t r_state, w_next;
    logic [1:0] r_cnt, w_cnt_next;
    logic [FLT_DATA_WIDTH-1:0] r_total, r_one, r_two, w_a, w_b, w_sum;
    logic [FLT_DATA_WIDTH-1:0] w_load_total, w_load_one, w_load_two;
    logic w_busy_start, w_load, w_drop;
    assign w_busy_start = start && r_state != IDLE;
    assign done = r_state == DONE;
    assign w_a = r_state == ADD_TWO ? w_sum : r_total;
    assign w_b = r_state == ADD_TWO ? r_two : r_one;
`ifdef FP_ACC_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [FLT_DATA_WIDTH-1:0] r_q_one [FIFO_DEPTH];
    logic [FLT_DATA_WIDTH-1:0] r_q_two [FIFO_DEPTH];
    logic [PW-1:0] r_rd, r_wr;
    logic [PW:0] r_fill;
    logic w_pop, w_bypass, w_push;
    assign w_pop = r_state == DONE && (r_fill != '0 || w_busy_start);
    assign w_bypass = w_pop && r_fill == '0;
    assign w_push = w_busy_start && !w_bypass && (r_fill != (PW+1)'(FIFO_DEPTH) || w_pop);
    assign w_drop = w_busy_start && !w_bypass && !w_push;
    assign w_load = (r_state == IDLE && start) || w_pop;
    assign w_load_total = r_state == DONE ? new_total : curent_total;
    assign w_load_one = (r_state == IDLE || w_bypass) ? to_add_one : r_q_one[r_rd];
    assign w_load_two = (r_state == IDLE || w_bypass) ? to_add_two : r_q_two[r_rd];
    assign working = r_state != IDLE || r_fill != '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_rd <= '0;
            r_wr <= '0;
            r_fill <= '0;
        end else if (clk_en) begin
            r_wr <= r_wr + PW'(w_push);
            r_rd <= r_rd + PW'(w_pop && !w_bypass);
            r_fill <= r_fill + (PW+1)'(w_push) - (PW+1)'(w_pop && !w_bypass);
        end
    always_ff @(posedge clk)
        if (clk_en && w_push) begin
            r_q_one[r_wr] <= to_add_one;
            r_q_two[r_wr] <= to_add_two;
        end
`else
    assign w_drop = w_busy_start;
    assign w_load = r_state == IDLE && start;
    assign w_load_total = curent_total;
    assign w_load_one = to_add_one;
    assign w_load_two = to_add_two;
    assign working = r_state != IDLE;
`endif
    always_comb begin
        w_next = r_state;
        w_cnt_next = r_cnt + 2'd1;
        case (r_state)
            IDLE, DONE: begin
                w_next = w_load ? ADD_ONE : IDLE;
                w_cnt_next = '0;
            end
            ADD_ONE: if (r_cnt == 2'(ADD_LATENCY - 1)) begin
                w_next = ADD_TWO;
                w_cnt_next = '0;
            end
            ADD_TWO: if (r_cnt == 2'(ADD_LATENCY)) begin
                w_next = DONE;
                w_cnt_next = '0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_total <= FP_POS_ZERO;
            r_one <= FP_POS_ZERO;
            r_two <= FP_POS_ZERO;
            new_total <= FP_POS_ZERO;
            overrun <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_next;
            r_cnt <= w_cnt_next;
            if (w_load) begin
                r_total <= w_load_total;
                r_one <= w_load_one;
                r_two <= w_load_two;
            end
            if (r_state == ADD_TWO && w_next == DONE) new_total <= w_sum;
            if (w_drop) overrun <= 1'b1;
        end
    fp_add_core u_add (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_sum  (w_sum)
    );
endmodule

// File: tb/tb_fp_pair_accumulator.sv
// tb_fp_pair_accumulator: scoreboard bench for fp_pair_accumulator (honours FP_ACC_FIFO_EN)
module tb_fp_pair_accumulator;
    logic clk, rst, clk_en, start, done, working, overrun, prev_done;
    logic [31:0] curent_total, to_add_one, to_add_two, new_total;
    logic [31:0] q[$];
    int n_chk, n_fail, cyc, s_cyc, d_cyc;
`ifdef FP_ACC_FIFO_EN
    localparam logic EXP_OVR = 1'b0;
`else
    localparam logic EXP_OVR = 1'b1;
`endif
    fp_pair_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .start        (start),
        .curent_total (curent_total),
        .to_add_one   (to_add_one),
        .to_add_two   (to_add_two),
        .new_total    (new_total),
        .done         (done),
        .working      (working),
        .overrun      (overrun)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        if (done && !prev_done) begin
            d_cyc = cyc;
            check("done_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) check("new_total", new_total, q.pop_front());
        end
        prev_done = done;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse(input logic [31:0] t, input logic [31:0] o, input logic [31:0] w);
        start = 1'b1;
        curent_total = t;
        to_add_one = o;
        to_add_two = w;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_idle();
        int n;
        n = 0;
        while ((working || q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n >= 200), 32'd0);
    endtask
    task automatic run(input logic [31:0] t, input logic [31:0] o, input logic [31:0] w, input logic [31:0] e);
        q.push_back(e);
        pulse(t, o, w);
        wait_idle();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        clk_en = 1'b1;
        start = 1'b0;
        curent_total = '0;
        to_add_one = '0;
        to_add_two = '0;
        tick();
        tick();
        check("rst_new_total", new_total, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_working", 32'(working), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();
        q.push_back(32'h3FE00000);
        pulse(32'h3F800000, 32'h3F000000, 32'h3E800000);
        for (int k = 1; k <= 9; k++) begin
            check("working_profile", 32'(working), 32'(k <= 8));
            check("done_profile", 32'(done), 32'(k == 8));
            tick();
        end
        wait_idle();
        check("latency", 32'(d_cyc - s_cyc), 32'd8);
        run(32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000);
        run(32'h40000000, 32'h00000001, 32'h00000000, 32'h40000000);
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h7F800000);
        run(32'h3F800000, 32'hFF800000, 32'h00000000, 32'hFF800000);
        run(32'h40400000, 32'hBF800000, 32'h3F000000, 32'h40200000);
        run(32'h3F800000, 32'hB3000000, 32'h00000000, 32'h3F7FFFFF);
        run(32'h3F800000, 32'h33800000, 32'h00000000, 32'h3F800000);
        run(32'h00C00000, 32'h80800000, 32'h00000000, 32'h00000000);
        check("overrun_clear", 32'(overrun), 32'd0);
        q.push_back(32'h3FE00000);
        pulse(32'h3F800000, 32'h3F000000, 32'h3E800000);
        tick();
        clk_en = 1'b0;
        repeat (5) tick();
        clk_en = 1'b1;
        wait_idle();
        check("latency_stall", 32'(d_cyc - s_cyc), 32'd13);
`ifdef FP_ACC_FIFO_EN
        q.push_back(32'h40000000);
        q.push_back(32'h40800000);
        q.push_back(32'h40C00000);
`else
        q.push_back(32'h40000000);
`endif
        pulse(32'h00000000, 32'h3F800000, 32'h3F800000);
        tick();
        pulse(32'h00000000, 32'h3F800000, 32'h3F800000);
        tick();
        pulse(32'h00000000, 32'h3F800000, 32'h3F800000);
        wait_idle();
        check("overrun_burst", 32'(overrun), 32'(EXP_OVR));
        q.push_back(32'h40800000);
        pulse(32'h40000000, 32'h3F800000, 32'h3F800000);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("async_rst_new_total", new_total, 32'h0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_working", 32'(working), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        run(32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40800000);
        check("latency_after_rst", 32'(d_cyc - s_cyc), 32'd8);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
